// File: rtl/act_bank_ring.sv
// ---------------------------------------------------------------------------
// act_bank_ring
//
// Rotating ring of NUM_BANKS activation banks (DEPTH x DATA_WIDTH each) with
// per-entry zero flags and a zero-skip scanner that streams the nonzero
// entries of the input bank over a valid/ready handshake.
//
// Bank mapping: input bank = in_ptr, output bank = (in_ptr+1) mod NUM_BANKS.
// A swap rotates the ring by one, so the old output bank becomes the new
// input bank with its contents intact. Swaps are only taken while the
// scanner is idle so a scan always sees one consistent input bank.
//
// Optional feature (macro ACT_RELU_EN): when defined, negative out_wr_data
// values are stored as zero (ReLU clamp) and flagged as zero. When the
// macro is undefined, out_wr_data is stored unmodified.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   swap_req / swap_ack        ring rotation request / taken pulse
//   in_bank                    index of the current input bank
//   in_clear / out_clear       clear the whole input / output bank
//   {in,out}_rd_en/addr/data   1-cycle registered read ports
//   {in,out}_wr_en/addr/data   write ports
//   in_zeros                   zero flags of the input bank
//   scan_start                 start a zero-skip scan of the input bank
//   scan_valid/ready           scan item handshake
//   scan_addr/data             current nonzero item
//   scan_done                  one-cycle pulse at scan completion
//   scan_busy                  scanner not idle
// ---------------------------------------------------------------------------
module act_bank_ring #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_BANKS  = 2,
    localparam int PTR_W     = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  swap_req,
    output logic                  swap_ack,
    output logic [PTR_W-1:0]      in_bank,
    input  logic                  in_clear,
    input  logic                  out_clear,
    input  logic                  in_rd_en,
    input  logic                  out_rd_en,
    input  logic [ADDR_WIDTH-1:0] in_rd_addr,
    input  logic [ADDR_WIDTH-1:0] out_rd_addr,
    output logic [DATA_WIDTH-1:0] in_rd_data,
    output logic [DATA_WIDTH-1:0] out_rd_data,
    input  logic                  in_wr_en,
    input  logic                  out_wr_en,
    input  logic [ADDR_WIDTH-1:0] in_wr_addr,
    input  logic [ADDR_WIDTH-1:0] out_wr_addr,
    input  logic [DATA_WIDTH-1:0] in_wr_data,
    input  logic [DATA_WIDTH-1:0] out_wr_data,
    output logic [DEPTH-1:0]      in_zeros,
    input  logic                  scan_start,
    output logic                  scan_valid,
    input  logic                  scan_ready,
    output logic [ADDR_WIDTH-1:0] scan_addr,
    output logic [DATA_WIDTH-1:0] scan_data,
    output logic                  scan_done,
    output logic                  scan_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEEK    = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } scan_state_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic is_zero(input logic [DATA_WIDTH-1:0] v);
        return (v == {DATA_WIDTH{1'b0}});
    endfunction

    // Value actually stored for an output-bank write.
    function automatic logic [DATA_WIDTH-1:0] out_store_val(input logic [DATA_WIDTH-1:0] v);
`ifdef ACT_RELU_EN
        return v[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : v;
`else
        return v;
`endif
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [NUM_BANKS][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [NUM_BANKS][DEPTH];
    logic [DEPTH-1:0]      zf_q  [NUM_BANKS];
    logic [DEPTH-1:0]      zf_d  [NUM_BANKS];

    logic [PTR_W-1:0]      in_ptr_q, in_ptr_d;
    logic [PTR_W-1:0]      out_ptr_s;
    logic                  swap_fire_s;
    logic [DATA_WIDTH-1:0] out_wdata_s;
    logic [DEPTH-1:0]      zf_in_s;

    logic [DATA_WIDTH-1:0] in_rd_data_q, in_rd_data_d;
    logic [DATA_WIDTH-1:0] out_rd_data_q, out_rd_data_d;

    scan_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cursor_q, cursor_d;
    logic [ADDR_WIDTH-1:0] scan_addr_q, scan_addr_d;
    logic [DATA_WIDTH-1:0] scan_data_q, scan_data_d;
    logic                  scan_valid_q, scan_valid_d;
    logic                  scan_done_q, scan_done_d;
    logic                  scan_busy_q, scan_busy_d;

    logic                  seek_hit_s;
    logic [ADDR_WIDTH-1:0] seek_idx_s;

    // ------------------------------------------------------------------
    // Mapping and swap control
    // ------------------------------------------------------------------
    // Output bank is the ring successor of the input bank.
    always_comb begin
        if (in_ptr_q == PTR_W'(NUM_BANKS - 1)) begin
            out_ptr_s = {PTR_W{1'b0}};
        end else begin
            out_ptr_s = in_ptr_q + PTR_W'(1);
        end
    end

    // A swap is only taken while the scanner is idle; the ack is the
    // same-cycle acceptance indication, the pointer moves at the edge.
    always_comb begin
        swap_fire_s = swap_req && (state_q == S_IDLE);
        if (swap_fire_s) begin
            in_ptr_d = out_ptr_s;
        end else begin
            in_ptr_d = in_ptr_q;
        end
    end

    assign swap_ack    = swap_fire_s;
    assign in_bank     = in_ptr_q;
    assign out_wdata_s = out_store_val(out_wr_data);
    assign zf_in_s     = zf_q[in_ptr_q];
    assign in_zeros    = zf_in_s;

    // ------------------------------------------------------------------
    // Bank storage next-state: clear wins over write within a bank
    // ------------------------------------------------------------------
    // Bank contents and zero flags next-state.
    always_comb begin
        mem_d = mem_q;
        zf_d  = zf_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (PTR_W'(b) == in_ptr_q) begin
                if (in_clear) begin
                    for (int e = 0; e < DEPTH; e++) begin
                        mem_d[b][e] = {DATA_WIDTH{1'b0}};
                    end
                    zf_d[b] = {DEPTH{1'b1}};
                end else if (in_wr_en) begin
                    mem_d[b][in_wr_addr] = in_wr_data;
                    zf_d[b][in_wr_addr]  = is_zero(in_wr_data);
                end else begin
                    zf_d[b] = zf_q[b];
                end
            end else if (PTR_W'(b) == out_ptr_s) begin
                if (out_clear) begin
                    for (int e = 0; e < DEPTH; e++) begin
                        mem_d[b][e] = {DATA_WIDTH{1'b0}};
                    end
                    zf_d[b] = {DEPTH{1'b1}};
                end else if (out_wr_en) begin
                    mem_d[b][out_wr_addr] = out_wdata_s;
                    zf_d[b][out_wr_addr]  = is_zero(out_wdata_s);
                end else begin
                    zf_d[b] = zf_q[b];
                end
            end else begin
                zf_d[b] = zf_q[b];
            end
        end
    end

    // Bank contents and zero flags registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[b][e] <= {DATA_WIDTH{1'b0}};
                end
                zf_q[b] <= {DEPTH{1'b1}};
            end
        end else begin
            mem_q <= mem_d;
            zf_q  <= zf_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: data holds while rd_en is low
    // ------------------------------------------------------------------
    // Registered read data next-state using the current (pre-swap) mapping.
    always_comb begin
        if (in_rd_en) begin
            in_rd_data_d = mem_q[in_ptr_q][in_rd_addr];
        end else begin
            in_rd_data_d = in_rd_data_q;
        end
        if (out_rd_en) begin
            out_rd_data_d = mem_q[out_ptr_s][out_rd_addr];
        end else begin
            out_rd_data_d = out_rd_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Zero-skip scanner
    // ------------------------------------------------------------------
    // Lowest nonzero entry at or after the cursor; the descending loop
    // lets the lowest matching index win.
    always_comb begin
        seek_hit_s = 1'b0;
        seek_idx_s = {ADDR_WIDTH{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!zf_in_s[i] && (ADDR_WIDTH'(i) >= cursor_q)) begin
                seek_hit_s = 1'b1;
                seek_idx_s = ADDR_WIDTH'(i);
            end else begin
                seek_hit_s = seek_hit_s;
            end
        end
    end

    // Scanner next-state; outputs are decoded from the next state so they
    // come straight out of flops.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        scan_addr_d = scan_addr_q;
        scan_data_d = scan_data_q;
        case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    state_d  = S_SEEK;
                    cursor_d = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEEK: begin
                if (seek_hit_s) begin
                    scan_addr_d = seek_idx_s;
                    scan_data_d = mem_q[in_ptr_q][seek_idx_s];
                    state_d     = S_PRESENT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PRESENT: begin
                if (scan_ready) begin
                    // The last entry has no successor; finishing here also
                    // keeps the cursor from wrapping back to 0.
                    if (scan_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        cursor_d = scan_addr_q + ADDR_WIDTH'(1);
                        state_d  = S_SEEK;
                    end
                end else begin
                    state_d = S_PRESENT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        scan_valid_d = (state_d == S_PRESENT);
        scan_done_d  = (state_d == S_DONE);
        scan_busy_d  = (state_d != S_IDLE);
    end

    // Scanner FSM, ring pointer and read-data registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cursor_q      <= {ADDR_WIDTH{1'b0}};
            scan_addr_q   <= {ADDR_WIDTH{1'b0}};
            scan_data_q   <= {DATA_WIDTH{1'b0}};
            scan_valid_q  <= 1'b0;
            scan_done_q   <= 1'b0;
            scan_busy_q   <= 1'b0;
            in_ptr_q      <= {PTR_W{1'b0}};
            in_rd_data_q  <= {DATA_WIDTH{1'b0}};
            out_rd_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            scan_addr_q   <= scan_addr_d;
            scan_data_q   <= scan_data_d;
            scan_valid_q  <= scan_valid_d;
            scan_done_q   <= scan_done_d;
            scan_busy_q   <= scan_busy_d;
            in_ptr_q      <= in_ptr_d;
            in_rd_data_q  <= in_rd_data_d;
            out_rd_data_q <= out_rd_data_d;
        end
    end

    assign in_rd_data  = in_rd_data_q;
    assign out_rd_data = out_rd_data_q;
    assign scan_valid  = scan_valid_q;
    assign scan_addr   = scan_addr_q;
    assign scan_data   = scan_data_q;
    assign scan_done   = scan_done_q;
    assign scan_busy   = scan_busy_q;

endmodule
